// File: rtl/dmem_mmio_pkg.sv
`default_nettype none
// ============================================================================
// dmem_mmio_pkg : register offsets, status layout and region decode helper
// Rev 1.0
// ============================================================================
package dmem_mmio_pkg;

  localparam logic [7:0] OFF_OUT       = 8'h00;
  localparam logic [7:0] OFF_CYCLE     = 8'h04;
  localparam logic [7:0] OFF_TX_DATA   = 8'h08;
  localparam logic [7:0] OFF_TX_STATUS = 8'h0C;
  localparam logic [7:0] OFF_DROPS     = 8'h10;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  // RAM takes priority; the peripheral page is matched on Addr[31:8].
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [23:0] mmio_page);
    region_e r;
    if (addr < ram_bytes)              r = REG_RAM;
    else if (addr[31:8] == mmio_page)  r = REG_MMIO;
    else                               r = REG_NONE;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_mmio_if.sv
`default_nettype none
// ============================================================================
// dmem_mmio_if : core load/store bus plus TX byte drain port
// Rev 1.0
// ============================================================================
interface dmem_mmio_if;
  import dmem_mmio_pkg::*;

  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] out_reg;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output MemWrite, Addr, WriteData, tx_ready,
    input  ReadData, out_reg, tx_data, tx_valid
  );

  modport slave (
    input  MemWrite, Addr, WriteData, tx_ready,
    output ReadData, out_reg, tx_data, tx_valid
  );
endinterface
`default_nettype wire

// File: rtl/dmem_mmio_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : show-ahead synchronous FIFO with registered count/full/empty
// Rev 1.0
// ============================================================================
module sync_fifo
  import dmem_mmio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok;
  logic             pop_ok;

  // Acceptance is judged on start-of-cycle flags, so a pop cannot make room
  // for a push in the same cycle.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// dmem_mmio : data RAM plus OUT/CYCLE/TX FIFO/DROPS peripheral window
// Rev 1.0
// ============================================================================
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic         CLK,
  input  logic         Reset,
  dmem_mmio_if.slave   bus
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  region_e        region;
  logic [5:0]     woff;
  logic [AW-1:0]  ram_idx;
  logic           mmio_wr;
  logic           wr_ram, wr_out, wr_cycle, wr_tx, wr_drops;

  logic [31:0]    ram_q [RAM_WORDS];
  logic [31:0]    out_q, out_d;
  logic [31:0]    cycle_q, cycle_d;
  logic [31:0]    drops_q, drops_d;

  logic [7:0]     fifo_head;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [31:0]    status;
  logic [31:0]    rdata;

  assign region  = decode_region(bus.Addr, 32'(RAM_WORDS * 4), MMIO_BASE[31:8]);
  assign woff    = bus.Addr[7:2];
  assign ram_idx = bus.Addr[AW+1:2];

  assign mmio_wr  = bus.MemWrite && (region == REG_MMIO);
  assign wr_ram   = bus.MemWrite && (region == REG_RAM);
  assign wr_out   = mmio_wr && (woff == OFF_OUT[7:2]);
  assign wr_cycle = mmio_wr && (woff == OFF_CYCLE[7:2]);
  assign wr_tx    = mmio_wr && (woff == OFF_TX_DATA[7:2]);
  assign wr_drops = mmio_wr && (woff == OFF_DROPS[7:2]);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (CLK),
    .rst       (Reset),
    .push      (wr_tx),
    .push_data (bus.WriteData[7:0]),
    .pop       (!fifo_empty && bus.tx_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    out_d   = wr_out ? bus.WriteData : out_q;
    cycle_d = wr_cycle ? bus.WriteData : cycle_q + 32'd1;
    drops_d = drops_q;
    // A push into a full FIFO counts as dropped even if a pop frees a slot.
    if (wr_drops)
      drops_d = '0;
    else if (wr_tx && fifo_full && (drops_q != '1))
      drops_d = drops_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      out_q   <= '0;
      cycle_q <= '0;
      drops_q <= '0;
    end else begin
      out_q   <= out_d;
      cycle_q <= cycle_d;
      drops_q <= drops_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset && wr_ram) ram_q[ram_idx] <= bus.WriteData;
  end

  always_comb begin
    status               = '0;
    status[ST_FULL]      = fifo_full;
    status[ST_EMPTY]     = fifo_empty;
    status[ST_COUNT_LSB +: 8] = 8'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    case (region)
      REG_RAM:  rdata = ram_q[ram_idx];
      REG_MMIO: begin
        if      (woff == OFF_OUT[7:2])       rdata = out_q;
        else if (woff == OFF_CYCLE[7:2])     rdata = cycle_q;
        else if (woff == OFF_TX_STATUS[7:2]) rdata = status;
        else if (woff == OFF_DROPS[7:2])     rdata = drops_q;
        else                                 rdata = '0;
      end
      default:  rdata = '0;
    endcase
  end

  assign bus.ReadData = rdata;
  assign bus.out_reg  = out_q;
  assign bus.tx_data  = fifo_head;
  assign bus.tx_valid = !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
// tb_dmem_mmio : directed + random stimulus against a queue-based model
// Rev 1.0
// ============================================================================
module tb_dmem_mmio;

  localparam int          RAM_WORDS  = 64;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [31:0] A_OUT   = 32'hFFFF_FF00;
  localparam logic [31:0] A_CYC   = 32'hFFFF_FF04;
  localparam logic [31:0] A_TXD   = 32'hFFFF_FF08;
  localparam logic [31:0] A_STAT  = 32'hFFFF_FF0C;
  localparam logic [31:0] A_DROPS = 32'hFFFF_FF10;

  logic CLK;
  logic Reset;
  dmem_mmio_if bus ();

  dmem_mmio #(
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MMIO_BASE  (32'hFFFF_FF00)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    bit          chk_rd;
    logic [31:0] rd;
    bit          chk_st;
    logic [31:0] outr;
    bit          vld;
    logic [7:0]  head;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   fails   = 0;

  // Reference model: plain state, FIFO as a byte queue, RAM as a word array.
  bit          m_valid = 0;
  logic [31:0] m_out, m_cyc, m_drops;
  logic [7:0]  m_q[$];
  logic [31:0] m_ram [RAM_WORDS];
  bit          m_known [RAM_WORDS];

  task automatic model_read(input logic [31:0] addr, output bit chk, output logic [31:0] rd);
    int idx;
    chk = 1;
    rd  = 32'h0;
    if (addr < RAM_WORDS * 4) begin
      idx = int'(addr >> 2);
      chk = m_known[idx];
      rd  = m_ram[idx];
    end else if (addr[31:8] == 24'hFFFFFF) begin
      case (addr[7:0] & 8'hFC)
        8'h00: rd = m_out;
        8'h04: rd = m_cyc;
        8'h0C: rd = {16'h0, 8'(m_q.size()), 6'h0, m_q.size() == 0, m_q.size() == FIFO_DEPTH};
        8'h10: rd = m_drops;
        default: rd = 32'h0;
      endcase
    end
  endtask

  task automatic model_update(input bit rst, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit rdy);
    bit was_full;
    bit mmio;
    logic [7:0] off;
    if (rst) begin
      m_valid = 1;
      m_out   = 0;
      m_cyc   = 0;
      m_drops = 0;
      m_q.delete();
      return;
    end
    mmio     = we && (addr >= RAM_WORDS * 4) && (addr[31:8] == 24'hFFFFFF);
    off      = addr[7:0] & 8'hFC;
    was_full = (m_q.size() == FIFO_DEPTH);
    m_cyc    = (mmio && off == 8'h04) ? wdata : m_cyc + 1;
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (mmio && off == 8'h08) begin
      if (was_full) begin
        if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
      end else begin
        m_q.push_back(wdata[7:0]);
      end
    end
    if (mmio && off == 8'h10) m_drops = 0;
    if (mmio && off == 8'h00) m_out = wdata;
    if (we && addr < RAM_WORDS * 4) begin
      m_ram[int'(addr >> 2)]   = wdata;
      m_known[int'(addr >> 2)] = 1;
    end
  endtask

  task automatic step(input bit rst, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit rdy, input string tag);
    exp_t e;
    @(posedge CLK);
    #1;
    Reset         = rst;
    bus.MemWrite  = we;
    bus.Addr      = addr;
    bus.WriteData = wdata;
    bus.tx_ready  = rdy;
    e.tag    = tag;
    model_read(addr, e.chk_rd, e.rd);
    e.chk_rd = e.chk_rd && m_valid;
    e.chk_st = m_valid;
    e.outr   = m_out;
    e.vld    = (m_q.size() != 0);
    e.head   = e.vld ? m_q[0] : 8'h00;
    sb.push_back(e);
    model_update(rst, we, addr, wdata, rdy);
  endtask

  // Monitor: consumes one expectation per cycle, away from the active edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.chk_rd) begin
          vectors++;
          if (bus.ReadData !== e.rd) begin
            fails++;
            $display("FAIL %s ReadData: got %08h expected %08h", e.tag, bus.ReadData, e.rd);
          end
        end
        if (e.chk_st) begin
          vectors++;
          if (bus.tx_valid !== e.vld || bus.tx_data !== e.head || bus.out_reg !== e.outr) begin
            fails++;
            $display("FAIL %s outputs: got valid=%0b data=%02h out=%08h expected valid=%0b data=%02h out=%08h",
                     e.tag, bus.tx_valid, bus.tx_data, bus.out_reg, e.vld, e.head, e.outr);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    logic [7:0]  offs [7];
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h80};
    case ($urandom_range(0, 9))
      0, 1, 2: a = {24'h0, 8'($urandom_range(0, 255))};
      3, 4, 5, 6: a = {24'hFFFFFF, offs[$urandom_range(0, 6)] | 8'($urandom_range(0, 3))};
      7: a = 32'h0000_0100 + 32'($urandom_range(0, 32'h0FFF_FFFF));
      default: a = A_TXD;
    endcase
    return a;
  endfunction

  initial begin : stim
    bit ready_bias;
    Reset = 1'b1;
    bus.MemWrite = 1'b0;
    bus.Addr = '0;
    bus.WriteData = '0;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < RAM_WORDS; i++) m_known[i] = 0;

    step(1, 0, 32'h0, 32'h0, 0, "reset");
    step(1, 0, 32'h0, 32'h0, 0, "reset");

    for (int i = 0; i < 3; i++) step(0, 0, A_CYC, 32'h0, 0, "cycle_count");
    step(0, 1, A_CYC, 32'hFFFF_FFFE, 0, "cycle_load");
    for (int i = 0; i < 3; i++) step(0, 0, A_CYC, 32'h0, 0, "cycle_wrap");

    step(0, 1, 32'h10, 32'h1111_1111, 0, "ram_init");
    step(0, 1, 32'h10, 32'hDEAD_BEEF, 0, "ram_same_cycle");
    step(0, 0, 32'h10, 32'h0, 0, "ram_load");
    step(0, 0, 32'h400, 32'h0, 0, "unmapped");

    step(0, 1, A_TXD, 32'h41, 0, "tx_push");
    step(0, 1, A_TXD, 32'h42, 0, "tx_push");
    step(0, 1, A_TXD, 32'h43, 0, "tx_push");
    step(0, 0, A_STAT, 32'h0, 0, "status_three");
    for (int i = 0; i < 4; i++) step(0, 0, A_STAT, 32'h0, 1, "tx_drain");

    for (int i = 0; i < 10; i++) step(0, 1, A_TXD, 32'h50 + 32'(i), 0, "ovf_push");
    step(0, 0, A_STAT, 32'h0, 0, "ovf_status");
    step(0, 0, A_DROPS, 32'h0, 0, "ovf_drops");
    for (int i = 0; i < 9; i++) step(0, 0, A_STAT, 32'h0, 1, "ovf_drain");
    step(0, 1, A_DROPS, 32'h1234_5678, 0, "drops_clear");
    step(0, 0, A_DROPS, 32'h0, 0, "drops_read");

    for (int i = 0; i < 8; i++) step(0, 1, A_TXD, 32'h60 + 32'(i), 0, "fill");
    step(0, 1, A_TXD, 32'h99, 1, "full_push_pop");
    step(0, 0, A_STAT, 32'h0, 0, "fpp_status");
    step(0, 0, A_DROPS, 32'h0, 0, "fpp_drops");
    for (int i = 0; i < 8; i++) step(0, 0, A_STAT, 32'h0, 1, "fpp_drain");

    step(0, 1, A_OUT, 32'h1234, 0, "out_write");
    step(0, 1, A_DROPS, 32'h0, 0, "drops_clear2");
    for (int i = 0; i < 13; i++) step(0, 1, A_TXD, 32'h70 + 32'(i), 0, "mid_fill");
    for (int i = 0; i < 5; i++) step(0, 0, A_DROPS, 32'h0, 1, "mid_drain");
    step(0, 0, A_STAT, 32'h0, 0, "mid_status");
    step(1, 1, A_TXD, 32'h77, 0, "reset_push");
    step(0, 0, A_CYC, 32'h0, 0, "post_reset_cycle");
    step(0, 0, A_STAT, 32'h0, 0, "post_reset_status");
    step(0, 0, A_DROPS, 32'h0, 0, "post_reset_drops");
    step(0, 0, A_OUT, 32'h0, 0, "post_reset_out");

    ready_bias = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) ready_bias = ($urandom_range(0, 1) == 1);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), rand_addr(), $urandom(),
           ready_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0), "random");
    end

    step(0, 0, A_STAT, 32'h0, 0, "final_status");
    repeat (3) @(posedge CLK);
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
